// File: rtl/al_accel_pkg.sv
// Shared definitions for the CNN accelerator accumulator-matrix control path:
// FSM state encoding, default counter width and performance counter width.
package al_accel_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int PERF_W    = 32;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] BIAS = 3'd2;
   localparam logic [2:0] WAIT = 3'd3;
   localparam logic [2:0] ACC  = 3'd4;
   localparam logic [2:0] OUT  = 3'd5;
   localparam logic [2:0] DONE = 3'd6;

endpackage

// File: rtl/al_accel_tile_counter.sv
// Loadable, enabled up-counter with a terminal flag (count == limit-1).
// Used for both the input-tile and the output-group index.
module al_accel_tile_counter
   import al_accel_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         last
);

   // load has priority over increment; caller guarantees no wrap
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   count <= '0;
      else if (load) count <= load_val;
      else if (inc)  count <= count + W'(1);
   end

   assign last = (count == limit - W'(1));

endmodule

// File: rtl/al_accel_acc_ctrl.sv
// Accumulator-matrix sequencer: per output group it strobes bias load and
// bias write, accumulates one handshaked tile per input-channel tile, then
// presents the group result downstream. enb low freezes everything.
// Optional macro AL_ACCEL_ACC_CTRL_PERF_EN adds busy/stall cycle counters.
module al_accel_acc_ctrl
   import al_accel_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enb,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_in_tiles,
   input  logic [CNT_W-1:0] cfg_out_groups,
   input  logic             di_valid,
   output logic             di_ready,
   output logic             acc_matrix_bps_load,
   output logic             acc_matrix_bps_write,
   output logic             acc_matrix_inter_sum_write,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] tile_idx,
   output logic [CNT_W-1:0] group_idx
`ifdef AL_ACCEL_ACC_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_cycles,
   output logic [PERF_W-1:0] perf_stalls
`endif
);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] in_tiles_q, groups_q;
   logic             tile_last, grp_last;
   logic             start_acc, cfg_zero, out_hs, next_grp;

   // handshakes only complete while enabled; state is frozen otherwise
   assign start_acc = enb && (state_q == IDLE) && start;
   assign cfg_zero  = (cfg_in_tiles == '0) || (cfg_out_groups == '0);
   assign out_hs    = enb && (state_q == OUT) && out_ready;
   assign next_grp  = out_hs && !grp_last;

   // job configuration is captured once so later cfg changes are ignored
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_tiles_q <= '0;
         groups_q   <= '0;
      end else if (start_acc) begin
         in_tiles_q <= cfg_in_tiles;
         groups_q   <= cfg_out_groups;
      end
   end

   al_accel_tile_counter #(.W(CNT_W)) u_tile_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .load     (start_acc || next_grp),
      .load_val ('0),
      .inc      (enb && (state_q == ACC) && !tile_last),
      .limit    (in_tiles_q),
      .count    (tile_idx),
      .last     (tile_last)
   );

   al_accel_tile_counter #(.W(CNT_W)) u_grp_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .load     (start_acc),
      .load_val ('0),
      .inc      (next_grp),
      .limit    (groups_q),
      .count    (group_idx),
      .last     (grp_last)
   );

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // next-state: only advances while enabled
   always_comb begin
      state_d = state_q;
      if (enb) begin
         case (state_q)
            IDLE: if (start) state_d = cfg_zero ? DONE : LOAD;
            LOAD: state_d = BIAS;
            BIAS: state_d = WAIT;
            WAIT: if (di_valid) state_d = ACC;
            ACC:  state_d = tile_last ? OUT : WAIT;
            OUT:  if (out_ready) state_d = grp_last ? DONE : LOAD;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Moore outputs; strobes gated by enb, out_valid/busy hold through stalls
   always_comb begin
      acc_matrix_bps_load        = enb && (state_q == LOAD);
      acc_matrix_bps_write       = enb && (state_q == BIAS);
      acc_matrix_inter_sum_write = enb && (state_q == ACC);
      di_ready                   = enb && (state_q == WAIT);
      done                       = enb && (state_q == DONE);
      out_valid                  = (state_q == OUT);
      busy                       = (state_q != IDLE);
   end

`ifdef AL_ACCEL_ACC_CTRL_PERF_EN
   logic [PERF_W-1:0] cyc_q, stl_q;
   logic              stall;

   assign stall = ((state_q == WAIT) && !di_valid) || ((state_q == OUT) && !out_ready);

   // saturating busy/stall counters, cleared when a job is accepted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cyc_q <= '0;
         stl_q <= '0;
      end else if (start_acc) begin
         cyc_q <= '0;
         stl_q <= '0;
      end else begin
         if (busy && (cyc_q != '1))  cyc_q <= cyc_q + PERF_W'(1);
         if (stall && (stl_q != '1)) stl_q <= stl_q + PERF_W'(1);
      end
   end

   assign perf_cycles = cyc_q;
   assign perf_stalls = stl_q;
`endif

endmodule

// File: tb/tb_al_accel_acc_ctrl.sv
// Self-checking bench for al_accel_acc_ctrl: directed cycle tables for the
// documented scenarios plus randomized jobs checked against a transaction
// level event-order model.
module tb_al_accel_acc_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             enb = 1'b0;
   logic             start = 1'b0;
   logic             di_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] cfg_in_tiles = '0;
   logic [CNT_W-1:0] cfg_out_groups = '0;
   logic             di_ready, bps_load, bps_write, isw, out_valid, busy, done;
   logic [CNT_W-1:0] tile_idx, group_idx;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   al_accel_acc_ctrl #(.CNT_W(CNT_W)) dut (
      .clk                        (clk),
      .resetn                     (resetn),
      .enb                        (enb),
      .start                      (start),
      .cfg_in_tiles               (cfg_in_tiles),
      .cfg_out_groups             (cfg_out_groups),
      .di_valid                   (di_valid),
      .di_ready                   (di_ready),
      .acc_matrix_bps_load        (bps_load),
      .acc_matrix_bps_write       (bps_write),
      .acc_matrix_inter_sum_write (isw),
      .out_valid                  (out_valid),
      .out_ready                  (out_ready),
      .busy                       (busy),
      .done                       (done),
      .tile_idx                   (tile_idx),
      .group_idx                  (group_idx)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // {bps_load, bps_write, inter_sum_write, di_ready, out_valid, done, busy}
   function automatic logic [6:0] obs();
      return {bps_load, bps_write, isw, di_ready, out_valid, done, busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int tiles, input int groups);
      cfg_in_tiles   = CNT_W'(tiles);
      cfg_out_groups = CNT_W'(groups);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; enb = 1'b1; di_valid = 1'b1; out_ready = 1'b1;
      repeat (5) tick();
      checks++;
      if (obs() !== 7'b0 || tile_idx !== '0 || group_idx !== '0) begin
         failures++;
         $display("FAIL reset_outputs got obs=%b tile=%0d group=%0d want obs=0000000 tile=0 group=0",
                  obs(), tile_idx, group_idx);
      end
      resetn = 1'b1;
      tick();
      checks++;
      if (obs() !== 7'b0) begin
         failures++;
         $display("FAIL idle_after_reset got obs=%b want 0000000", obs());
      end
   endtask

   task automatic test_single();
      logic [6:0] exp_tab [7];
      exp_tab = '{7'b1000001, 7'b0100001, 7'b0001001, 7'b0010001,
                  7'b0000101, 7'b0000011, 7'b0000000};
      enb = 1'b1; di_valid = 1'b1; out_ready = 1'b1;
      start_job(1, 1);
      for (int c = 0; c < 7; c++) begin
         checks++;
         if (obs() !== exp_tab[c]) begin
            failures++;
            $display("FAIL single_cycle%0d got obs=%b want %b", c + 1, obs(), exp_tab[c]);
         end
         tick();
      end
   endtask

   task automatic test_multi();
      int n_load = 0, n_isw = 0, n_done = 0;
      int gq[$];
      enb = 1'b1; di_valid = 1'b1; out_ready = 1'b1;
      start_job(3, 2);
      for (int c = 0; c < 60; c++) begin
         if (bps_load) begin n_load++; gq.push_back(int'(group_idx)); end
         if (isw) n_isw++;
         if (done) n_done++;
         tick();
      end
      checks++;
      if (n_load != 2) begin failures++; $display("FAIL multi_load_count got %0d want 2", n_load); end
      checks++;
      if (n_isw != 6) begin failures++; $display("FAIL multi_isw_count got %0d want 6", n_isw); end
      checks++;
      if (n_done != 1) begin failures++; $display("FAIL multi_done_count got %0d want 1", n_done); end
      checks++;
      if (gq.size() != 2 || gq[0] != 0 || gq[1] != 1) begin
         failures++;
         $display("FAIL multi_group_idx got size=%0d first=%0d want 0 then 1",
                  gq.size(), (gq.size() > 0) ? gq[0] : -1);
      end
   endtask

   task automatic test_stall_handshake();
      enb = 1'b1; di_valid = 1'b0; out_ready = 1'b0;
      start_job(1, 1);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs() !== 7'b0001001) begin
            failures++;
            $display("FAIL wait_hold%0d got obs=%b want 0001001", i, obs());
         end
         if (i == 4) di_valid = 1'b1;
         tick();
      end
      checks++;
      if (obs() !== 7'b0010001) begin
         failures++;
         $display("FAIL wait_to_acc got obs=%b want 0010001", obs());
      end
      di_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs() !== 7'b0000101) begin
            failures++;
            $display("FAIL out_hold%0d got obs=%b want 0000101", i, obs());
         end
         if (i == 3) out_ready = 1'b1;
         tick();
      end
      checks++;
      if (obs() !== 7'b0000011) begin
         failures++;
         $display("FAIL out_to_done got obs=%b want 0000011", obs());
      end
      tick();
   endtask

   task automatic test_enb_bias();
      logic [6:0] exp_tab [5];
      exp_tab = '{7'b0100001, 7'b0001001, 7'b0010001, 7'b0000101, 7'b0000011};
      enb = 1'b1; di_valid = 1'b1; out_ready = 1'b1;
      start_job(1, 1);
      tick();
      enb = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs() !== 7'b0000001) begin
            failures++;
            $display("FAIL bias_stall%0d got obs=%b want 0000001", i, obs());
         end
         tick();
      end
      enb = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (obs() !== exp_tab[c]) begin
            failures++;
            $display("FAIL bias_resume%0d got obs=%b want %b", c, obs(), exp_tab[c]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      enb = 1'b1; di_valid = 1'b1; out_ready = 1'b1;
      start_job(3, 1);
      for (int c = 0; c < 40 && !found; c++) begin
         if (isw && tile_idx == CNT_W'(2)) found = 1;
         else tick();
      end
      checks++;
      if (!found) begin failures++; $display("FAIL midreset_reach_acc2 got none want acc at tile 2"); end
      resetn = 1'b0;
      #1;
      checks++;
      if (obs() !== 7'b0 || tile_idx !== '0 || group_idx !== '0) begin
         failures++;
         $display("FAIL midreset_outputs got obs=%b tile=%0d group=%0d want 0", obs(), tile_idx, group_idx);
      end
      tick(); tick();
      resetn = 1'b1;
      tick();
      checks++;
      if (obs() !== 7'b0) begin failures++; $display("FAIL midreset_stays_idle got obs=%b want 0", obs()); end
      start_job(2, 1);
      checks++;
      if (obs() !== 7'b1000001 || tile_idx !== '0 || group_idx !== '0) begin
         failures++;
         $display("FAIL midreset_restart got obs=%b tile=%0d group=%0d want 1000001/0/0",
                  obs(), tile_idx, group_idx);
      end
      repeat (10) tick();
   endtask

   task automatic test_zero();
      int n_load = 0, n_isw = 0, n_done = 0;
      enb = 1'b1; di_valid = 1'b1; out_ready = 1'b1;
      start_job(0, 3);
      checks++;
      if (obs() !== 7'b0000011) begin failures++; $display("FAIL zero_tiles got obs=%b want 0000011", obs()); end
      tick();
      checks++;
      if (obs() !== 7'b0) begin failures++; $display("FAIL zero_tiles_idle got obs=%b want 0", obs()); end
      start_job(2, 0);
      checks++;
      if (obs() !== 7'b0000011) begin failures++; $display("FAIL zero_groups got obs=%b want 0000011", obs()); end
      tick();
      // second start while busy, with changed cfg, must be ignored
      cfg_in_tiles = CNT_W'(2); cfg_out_groups = CNT_W'(1);
      start = 1'b1;
      tick();
      cfg_in_tiles = CNT_W'(5); cfg_out_groups = CNT_W'(4);
      for (int c = 0; c < 40; c++) begin
         if (c == 3) start = 1'b0;
         if (bps_load) n_load++;
         if (isw) n_isw++;
         if (done) n_done++;
         tick();
      end
      checks++;
      if (n_load != 1 || n_isw != 2 || n_done != 1) begin
         failures++;
         $display("FAIL restart_ignored got load=%0d isw=%0d done=%0d want 1/2/1", n_load, n_isw, n_done);
      end
   endtask

   function automatic int ev(input int typ, input int g, input int t);
      return typ * 1000000 + g * 1000 + t;
   endfunction

   task automatic test_random();
      int gate_err = 0, stab_err = 0;
      for (int job = 0; job < 12; job++) begin
         int tiles = int'($urandom_range(1, 4));
         int groups = int'($urandom_range(1, 3));
         int expq[$];
         int gotq[$];
         bit fin = 0, prev_ov = 0, prev_hs = 0, bad = 0;
         for (int g = 0; g < groups; g++) begin
            expq.push_back(ev(1, g, 0));
            expq.push_back(ev(2, g, 0));
            for (int t = 0; t < tiles; t++) expq.push_back(ev(3, g, t));
            expq.push_back(ev(4, g, 0));
         end
         expq.push_back(ev(5, 0, 0));
         cfg_in_tiles = CNT_W'(tiles); cfg_out_groups = CNT_W'(groups);
         start = 1'b1;
         for (int c = 0; c < 2000 && !fin; c++) begin
            enb = ($urandom_range(0, 3) != 0);
            di_valid = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 1) != 0;
            #1;
            if (!enb && (bps_load || bps_write || isw || di_ready || done)) gate_err++;
            if (prev_ov && !prev_hs && !out_valid) stab_err++;
            if (bps_load) gotq.push_back(ev(1, int'(group_idx), int'(tile_idx)));
            if (bps_write) gotq.push_back(ev(2, int'(group_idx), int'(tile_idx)));
            if (isw) gotq.push_back(ev(3, int'(group_idx), int'(tile_idx)));
            if (out_valid && out_ready && enb) gotq.push_back(ev(4, int'(group_idx), 0));
            if (done) begin gotq.push_back(ev(5, 0, 0)); fin = 1; end
            if (busy) begin
               start = 1'b0;
               cfg_in_tiles = CNT_W'($urandom_range(0, 7));
               cfg_out_groups = CNT_W'($urandom_range(0, 7));
            end
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready && enb;
            tick();
         end
         start = 1'b0;
         if (gotq.size() != expq.size()) bad = 1;
         else foreach (expq[i]) if (gotq[i] != expq[i]) bad = 1;
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL random_job%0d events got n=%0d want n=%0d (tiles=%0d groups=%0d)",
                     job, gotq.size(), expq.size(), tiles, groups);
         end
      end
      checks++;
      if (gate_err != 0) begin failures++; $display("FAIL random_enb_gating got %0d violations want 0", gate_err); end
      checks++;
      if (stab_err != 0) begin failures++; $display("FAIL random_out_valid_stable got %0d drops want 0", stab_err); end
      enb = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_stall_handshake();
      test_enb_bias();
      test_reset_mid();
      test_zero();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
